// File: rtl/brisc_mem_latency_unit.sv
// brisc_mem_latency_unit: cache-line memory model with request/response latency and in-order queue
module brisc_mem_latency_unit #(
    parameter int ADDR_W          = 32,
    parameter int LINE_W          = 128,
    parameter int DEPTH_LINES     = 1024,
    parameter int REQ_DELAY       = 5,
    parameter int RESP_DELAY      = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [LINE_W-1:0] resp_rdata
);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam int IW  = $clog2(DEPTH_LINES);
    localparam int LAT = REQ_DELAY + RESP_DELAY;
    localparam int TW  = $clog2(LAT + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    logic [LINE_W-1:0] mem [DEPTH_LINES];
    logic              v_q    [MAX_OUTSTANDING];
    logic              v_d    [MAX_OUTSTANDING];
    logic              we_q   [MAX_OUTSTANDING];
    logic              we_d   [MAX_OUTSTANDING];
    logic [ADDR_W-1:0] addr_q [MAX_OUTSTANDING];
    logic [ADDR_W-1:0] addr_d [MAX_OUTSTANDING];
    logic [LINE_W-1:0] data_q [MAX_OUTSTANDING];
    logic [LINE_W-1:0] data_d [MAX_OUTSTANDING];
    logic [TW-1:0]     tmr_q  [MAX_OUTSTANDING];
    logic [TW-1:0]     tmr_d  [MAX_OUTSTANDING];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, acc_sel;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     acc_idx;
    logic              acc_hit, accept, retire;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_ready  = cnt_q < CW'(MAX_OUTSTANDING);
    assign resp_valid = v_q[head_q] && (tmr_q[head_q] == TW'(LAT));
    assign resp_we    = resp_valid & we_q[head_q];
    assign resp_addr  = resp_valid ? addr_q[head_q] : '0;
    assign resp_rdata = resp_valid ? data_q[head_q] : '0;
    assign accept     = req_valid && req_ready;
    assign retire     = resp_valid && resp_ready;
    assign acc_idx    = addr_q[acc_sel][OFF +: IW];

    // find the one entry whose array access lands on the coming edge (acceptances are one per cycle)
    always_comb begin
        acc_hit = 1'b0;
        acc_sel = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (v_q[i] && tmr_q[i] == TW'(REQ_DELAY - 1)) begin
                acc_hit = 1'b1;
                acc_sel = PW'(i);
            end
    end

    // next state: age timers, capture read data at access, retire head, enqueue at tail
    always_comb begin
        v_d    = v_q;
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        tmr_d  = tmr_q;
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (v_q[i] && tmr_q[i] != TW'(LAT)) tmr_d[i] = tmr_q[i] + TW'(1);
        if (acc_hit && !we_q[acc_sel]) data_d[acc_sel] = mem[acc_idx];
        if (retire) begin
            v_d[head_q] = 1'b0;
            head_d      = nxt(head_q);
        end
        if (accept) begin
            v_d[tail_q]    = 1'b1;
            we_d[tail_q]   = req_we;
            addr_d[tail_q] = req_addr & ~ADDR_W'(LINE_W / 8 - 1);
            data_d[tail_q] = req_wdata;
            tmr_d[tail_q]  = '0;
            tail_d         = nxt(tail_q);
        end
        cnt_d = cnt_q + CW'(accept) - CW'(retire);
    end

    // queue state; reset drops every in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '{default: '0};
            we_q   <= '{default: '0};
            addr_q <= '{default: '0};
            data_q <= '{default: '0};
            tmr_q  <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            tmr_q  <= tmr_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // backing array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (acc_hit && we_q[acc_sel]) mem[acc_idx] <= data_q[acc_sel];
    end
endmodule
